// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding a 2**ADDR_W x DATA_W register file.
// Retires one entry per cycle as a one-hot write enable and provides two read-bypass ports.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_reg,
  input  logic [DATA_W-1:0]   in_data,
  output logic [DATA_W-1:0]   wr_data,
  output logic [2**ADDR_W-1:0] wr_enable,
  input  logic [ADDR_W-1:0]   rd_reg1,
  input  logic [ADDR_W-1:0]   rd_reg2,
  output logic                byp_hit1,
  output logic [DATA_W-1:0]   byp_data1,
  output logic                byp_hit2,
  output logic [DATA_W-1:0]   byp_data2,
  output logic [ADDR_W:0]     pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int NREG  = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] reg_mem_r  [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [ADDR_W:0]   count_r;
  logic              push_s;
  logic              pop_s;
  logic [PTR_W-1:0]  slot_s;
  logic              occ_s;

  // Register 0 writes are acknowledged but never stored.
  assign in_ready = !rst && (count_r < DEPTH_V);
  assign push_s   = in_valid && in_ready && (in_reg != {ADDR_W{1'b0}});
  assign pop_s    = (count_r != {(ADDR_W+1){1'b0}});
  assign pending  = count_r;

  // Entry storage; contents are not cleared by reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      reg_mem_r[tail_r]  <= in_reg;
      data_mem_r[tail_r] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (ADDR_W+1)'(1);
        2'b01:   count_r <= count_r - (ADDR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry drives the register file whenever the queue is non-empty.
  always_comb begin
    wr_data   = {DATA_W{1'b0}};
    wr_enable = {NREG{1'b0}};
    if (pop_s) begin
      wr_data   = data_mem_r[head_r];
      wr_enable = NREG'(1) << reg_mem_r[head_r];
    end else begin
      wr_data   = {DATA_W{1'b0}};
      wr_enable = {NREG{1'b0}};
    end
  end

  // Bypass scan from oldest to youngest so the youngest match wins.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_data1 = {DATA_W{1'b0}};
    byp_hit2  = 1'b0;
    byp_data2 = {DATA_W{1'b0}};
    slot_s    = {PTR_W{1'b0}};
    occ_s     = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_s = head_r + PTR_W'(i);
      occ_s  = ((ADDR_W+1)'(i) < count_r);
      if (occ_s && (rd_reg1 != {ADDR_W{1'b0}}) && (reg_mem_r[slot_s] == rd_reg1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_mem_r[slot_s];
      end else begin
        byp_hit1  = byp_hit1;
        byp_data1 = byp_data1;
      end
      if (occ_s && (rd_reg2 != {ADDR_W{1'b0}}) && (reg_mem_r[slot_s] == rd_reg2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_mem_r[slot_s];
      end else begin
        byp_hit2  = byp_hit2;
        byp_data2 = byp_data2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Randomised and directed bench for regfile_write_queue against a queue-based reference model.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_reg;
  logic [15:0] in_data;
  logic [15:0] wr_data;
  logic [15:0] wr_enable;
  logic [3:0]  rd_reg1;
  logic [3:0]  rd_reg2;
  logic        byp_hit1;
  logic [15:0] byp_data1;
  logic        byp_hit2;
  logic [15:0] byp_data2;
  logic [4:0]  pending;

  int checks = 0;
  int errors = 0;

  logic [19:0] mq [$];
  logic [15:0] ret_q [$];

  regfile_write_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .wr_data(wr_data), .wr_enable(wr_enable),
    .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .byp_hit1(byp_hit1), .byp_data1(byp_data1),
    .byp_hit2(byp_hit2), .byp_data2(byp_data2),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model_byp(input logic [3:0] a);
    logic [16:0] r;
    r = 17'h0;
    if (a != 4'd0) begin
      foreach (mq[i]) begin
        if (mq[i][19:16] == a) r = {1'b1, mq[i][15:0]};
      end
    end
    return r;
  endfunction

  task automatic model_check();
    logic [16:0] b1;
    logic [16:0] b2;
    b1 = model_byp(rd_reg1);
    b2 = model_byp(rd_reg2);
    chk_eq("pending",   32'(pending),   32'(mq.size()));
    chk_eq("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    chk_eq("wr_enable", 32'(wr_enable), (mq.size() > 0) ? (32'd1 << mq[0][19:16]) : 32'd0);
    chk_eq("wr_data",   32'(wr_data),   (mq.size() > 0) ? 32'(mq[0][15:0]) : 32'd0);
    chk_eq("byp_hit1",  32'(byp_hit1),  32'(b1[16]));
    chk_eq("byp_data1", 32'(byp_data1), 32'(b1[15:0]));
    chk_eq("byp_hit2",  32'(byp_hit2),  32'(b2[16]));
    chk_eq("byp_data2", 32'(byp_data2), 32'(b2[15:0]));
  endtask

  // Drives one cycle's inputs, checks at the falling edge, advances the model, returns at posedge+1.
  task automatic cycle(input logic v, input logic [3:0] r, input logic [15:0] d,
                       input logic [3:0] a1, input logic [3:0] a2);
    logic accept;
    in_valid = v; in_reg = r; in_data = d; rd_reg1 = a1; rd_reg2 = a2;
    @(negedge clk);
    model_check();
    if (wr_enable != 16'h0) ret_q.push_back(wr_data);
    accept = v && (mq.size() < DEPTH);
    if (mq.size() > 0) void'(mq.pop_front());
    if (accept && (r != 4'd0)) mq.push_back({r, d});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg = 4'd0; in_data = 16'h0; rd_reg1 = 4'd0; rd_reg2 = 4'd0;
    @(posedge clk); #1;
    chk_eq("rst_pending",  32'(pending),   32'd0);
    chk_eq("rst_in_ready", 32'(in_ready),  32'd0);
    chk_eq("rst_wr_en",    32'(wr_enable), 32'd0);
    chk_eq("rst_wr_data",  32'(wr_data),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_eq("post_rst_ready", 32'(in_ready), 32'd1);

    // Single write to register 5.
    cycle(1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd0);
    chk_eq("single_pending", 32'(pending),   32'd1);
    chk_eq("single_we",      32'(wr_enable), 32'h0020);
    chk_eq("single_data",    32'(wr_data),   32'hBEEF);
    cycle(1'b0, 4'd0, 16'h0, 4'd5, 4'd0);
    chk_eq("single_pending0", 32'(pending),   32'd0);
    chk_eq("single_we0",      32'(wr_enable), 32'h0);

    // Back-to-back stream to registers 1..6.
    ret_q.delete();
    for (int i = 1; i <= 6; i++) cycle(1'b1, 4'(i), 16'(i * 256), 4'(i), 4'd2);
    cycle(1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    chk_eq("fill_count", 32'(ret_q.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < ret_q.size()) chk_eq("fill_order", 32'(ret_q[i]), 32'((i + 1) * 256));

    // Two writes to register 3; youngest value must be bypassed.
    cycle(1'b1, 4'd3, 16'h1111, 4'd3, 4'd4);
    chk_eq("byp_first", 32'(byp_data1), 32'h1111);
    cycle(1'b1, 4'd3, 16'h2222, 4'd3, 4'd4);
    chk_eq("byp_young_hit",  32'(byp_hit1),  32'd1);
    chk_eq("byp_young_data", 32'(byp_data1), 32'h2222);
    chk_eq("byp_miss2",      32'(byp_hit2),  32'd0);
    cycle(1'b0, 4'd0, 16'h0, 4'd3, 4'd4);
    chk_eq("byp_retired", 32'(byp_hit1), 32'd0);

    // Register 0 is accepted but dropped.
    cycle(1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0);
    chk_eq("r0_pending", 32'(pending),   32'd0);
    chk_eq("r0_we",      32'(wr_enable), 32'd0);
    chk_eq("r0_byp",     32'(byp_hit1),  32'd0);

    // Ten back-to-back writes wrap the pointers with simultaneous push and pop.
    ret_q.delete();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 4'(1 + (i % 15)), 16'(16'hA000 + i), 4'(1 + (i % 15)), 4'd0);
      chk_eq("wrap_pending", 32'(pending), 32'd1);
    end
    cycle(1'b0, 4'd0, 16'h0, 4'd0, 4'd0);
    chk_eq("wrap_count", 32'(ret_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < ret_q.size()) chk_eq("wrap_order", 32'(ret_q[i]), 32'(16'hA000 + i));

    // Randomised traffic over a small register range to exercise bypass hits.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 5)), 16'($urandom),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)));

    // Asynchronous reset between edges with a write in flight.
    cycle(1'b1, 4'd7, 16'h7777, 4'd7, 4'd0);
    chk_eq("arst_pre_pending", 32'(pending), 32'd1);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_eq("arst_we",      32'(wr_enable), 32'd0);
    chk_eq("arst_data",    32'(wr_data),   32'd0);
    chk_eq("arst_pending", 32'(pending),   32'd0);
    chk_eq("arst_ready",   32'(in_ready),  32'd0);
    chk_eq("arst_byp",     32'(byp_hit1),  32'd0);
    chk_eq("arst_bypd",    32'(byp_data1), 32'd0);
    mq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk_eq("arst_ready_back", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'd0, 16'h0, 4'd7, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
